mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and master indices for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RR     = 2'd0,
    LOCKED = 2'd1,
    FORCE  = 2'd2
  } arb_state_t;

  localparam int unsigned M_CORE   = 0;
  localparam int unsigned M_LOADER = 1;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported, one-cycle-latency memory
// between the core (master 0) and the loader/DMA (master 1), with a bounded
// bus lock for master 1 bursts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  arb_state_t    state;
  logic          last;
  logic [CW-1:0] lock_cnt;
  logic [1:0]    rd_owner;

  logic          g0;
  logic          g1;
  logic          cnt_max;

  assign cnt_max = (lock_cnt == CW'(LOCK_MAX));

  // Grant selection; once the lock budget is spent and the core waits,
  // master 1 is held off so the core gets the next slot.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      RR: begin
        if (m0_req && m1_req) begin
          if (last == 1'(M_LOADER)) g0 = 1'b1;
          else                      g1 = 1'b1;
        end else begin
          g0 = m0_req;
          g1 = m1_req;
        end
      end
      LOCKED: g1 = m1_req && !(cnt_max && m0_req);
      FORCE:  g0 = m0_req;
      default: begin
        g0 = 1'b0;
        g1 = 1'b0;
      end
    endcase
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  // Memory port mux; with no grant the core's address/data are presented.
  always_comb begin
    mem_adr   = g1 ? m1_adr : m0_adr;
    mem_wdata = g1 ? m1_wdata : m0_wdata;
    mem_we    = (g0 && m0_we) || (g1 && m1_we);
  end

  // Arbitration state, round-robin pointer, lock budget and read ownership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RR;
      last     <= 1'(M_LOADER);
      lock_cnt <= '0;
      rd_owner <= '0;
    end else begin
      if (g0)      last <= 1'(M_CORE);
      else if (g1) last <= 1'(M_LOADER);

      rd_owner[M_CORE]   <= g0 && !m0_we;
      rd_owner[M_LOADER] <= g1 && !m1_we;

      case (state)
        RR: begin
          if (g1 && m1_lock) begin
            state    <= LOCKED;
            lock_cnt <= CW'(1);
          end
        end
        LOCKED: begin
          if (cnt_max && m0_req) begin
            state <= FORCE;
          end else if (!m1_lock) begin
            state    <= RR;
            lock_cnt <= '0;
          end else if (g1 && !cnt_max) begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        FORCE: begin
          state    <= RR;
          last     <= 1'(M_CORE);
          lock_cnt <= '0;
        end
        default: begin
          state    <= RR;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = rd_owner[M_CORE];
  assign m1_rvalid = rd_owner[M_LOADER];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-grant lock budget.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_adr = 32'h55; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_adr = 0; m1_wdata = 0; m1_lock = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gnts(input string tag, input logic e0, input logic e1);
    chk({tag, "_g0"}, 64'(m0_gnt), 64'(e0));
    chk({tag, "_g1"}, 64'(m1_gnt), 64'(e1));
  endtask

  task automatic rvs(input string tag, input logic e0, input logic e1);
    chk({tag, "_rv0"}, 64'(m0_rvalid), 64'(e0));
    chk({tag, "_rv1"}, 64'(m1_rvalid), 64'(e1));
  endtask

  initial begin
    idle();
    mem_rdata = 0;
    rst = 1;
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    #2;
    gnts("rst", 0, 0);
    chk("rst_we", 64'(mem_we), 64'd0);
    rvs("rst", 0, 0);
    chk("rst_state", 64'(dut.state), 64'(RR));

    // Both masters read continuously after reset: 0,1,0,1
    cyc();
    rst = 0;
    idle();
    m0_req = 1; m0_adr = 32'h200;
    m1_req = 1; m1_adr = 32'h300;
    #1;
    gnts("alt1", 1, 0); chk("alt1_adr", 64'(mem_adr), 64'h200); rvs("alt1", 0, 0);
    cyc(); #1;
    gnts("alt2", 0, 1); chk("alt2_adr", 64'(mem_adr), 64'h300); rvs("alt2", 1, 0);
    cyc(); #1;
    gnts("alt3", 1, 0); chk("alt3_adr", 64'(mem_adr), 64'h200); rvs("alt3", 0, 1);
    cyc(); #1;
    gnts("alt4", 0, 1); chk("alt4_adr", 64'(mem_adr), 64'h300); rvs("alt4", 1, 0);
    cyc(); idle(); #1;
    gnts("alt5", 0, 0); rvs("alt5", 0, 1);
    chk("idle_adr", 64'(mem_adr), 64'h55);
    chk("idle_we", 64'(mem_we), 64'd0);

    // Master 0 single read at 0x100
    cyc();
    m0_req = 1; m0_adr = 32'h100;
    #1;
    gnts("rd", 1, 0); chk("rd_adr", 64'(mem_adr), 64'h100); chk("rd_we", 64'(mem_we), 64'd0);
    cyc(); idle(); mem_rdata = 32'hDEADBEEF; #1;
    rvs("rd1", 1, 0);
    chk("rd1_data", 64'(m0_rdata), 64'hDEADBEEF);
    cyc(); #1;
    rvs("rd2", 0, 0);

    // Master 1 write to 0x40, master 0 idle
    cyc();
    m1_req = 1; m1_we = 1; m1_adr = 32'h40; m1_wdata = 32'h12345678;
    #1;
    gnts("wr", 0, 1);
    chk("wr_we", 64'(mem_we), 64'd1);
    chk("wr_adr", 64'(mem_adr), 64'h40);
    chk("wr_data", 64'(mem_wdata), 64'h12345678);
    cyc(); idle(); #1;
    chk("wr1_we", 64'(mem_we), 64'd0);
    rvs("wr1", 0, 0);

    // Locked burst of writes; core joins after the first grant
    cyc();
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_adr = 32'h800;
    #1;
    gnts("lk0", 0, 1);
    cyc();
    m0_req = 1; m0_adr = 32'h500;
    #1;
    gnts("lk1", 0, 1); chk("lk1_state", 64'(dut.state), 64'(LOCKED));
    cyc(); #1; gnts("lk2", 0, 1);
    cyc(); #1; gnts("lk3", 0, 1);
    cyc(); #1; gnts("lk4", 0, 0);
    cyc(); #1; gnts("lkf", 1, 0); chk("lkf_adr", 64'(mem_adr), 64'h500);
    chk("lkf_state", 64'(dut.state), 64'(FORCE));
    cyc(); m1_lock = 0; #1;
    gnts("lkr1", 0, 1); rvs("lkr1", 1, 0);
    cyc(); #1;
    gnts("lkr2", 1, 0); rvs("lkr2", 0, 0);
    cyc(); idle(); #1;
    rvs("lkr3", 1, 0);

    // Lock dropped after two grants; core wins the next tie
    cyc();
    m1_req = 1; m1_we = 1; m1_lock = 1;
    #1;
    gnts("ld0", 0, 1);
    cyc();
    m0_req = 1; m0_adr = 32'h600;
    #1;
    gnts("ld1", 0, 1);
    cyc(); m1_lock = 0; #1;
    gnts("ld2", 0, 1);
    cyc(); #1;
    gnts("ld3", 1, 0); chk("ld3_state", 64'(dut.state), 64'(RR));
    chk("ld3_adr", 64'(mem_adr), 64'h600);
    cyc(); idle(); #1;

    // Reset the cycle after a granted read
    cyc();
    m0_req = 1; m0_adr = 32'h700;
    #1;
    gnts("rr0", 1, 0);
    cyc();
    rst = 1; idle(); m0_req = 1; m1_req = 1;
    #1;
    rvs("rr1", 0, 0);
    gnts("rr1", 0, 0);
    cyc();
    rst = 0;
    #1;
    rvs("rr2", 0, 0);
    chk("rr2_state", 64'(dut.state), 64'(RR));
    gnts("rr2", 1, 0);
    cyc(); idle(); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_arbiter
